// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side write bus of fifo_wr_arbiter: requests, per-requester data,
// grant, FIFO occupancy and the registered FIFO write port.
interface fifo_wr_arbiter_if #(
    parameter int N     = 4,
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
);
    logic [N-1:0]           req;
    logic [N*WIDTH-1:0]     req_data;
    logic [N-1:0]           gnt;
    logic [$clog2(DEPTH):0] fifo_cnt;
    logic                   fifo_write;
    logic [WIDTH-1:0]       fifo_data_in;
    logic [$clog2(N)-1:0]   gnt_id;

    modport master (
        output req, req_data, fifo_cnt,
        input  gnt, fifo_write, fifo_data_in, gnt_id
    );

    modport slave (
        input  req, req_data, fifo_cnt,
        output gnt, fifo_write, fifo_data_in, gnt_id
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter for one sync FIFO write port, throttled on FIFO occupancy.
// Define FIFO_ARB_BURST_EN to let a requester keep the grant for up to MAX_BURST transfers.
module fifo_wr_arbiter #(
    parameter int N         = 4,
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 16,
    parameter int MAX_BURST = 4
) (
    input logic              clk,
    input logic              rst,
    fifo_wr_arbiter_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int IW = $clog2(N);

    logic [IW-1:0]    last_q;
    logic [IW-1:0]    sel;
    logic [IW-1:0]    cand;
    logic             found;
    logic             room;
    logic [CW:0]      occ;
    logic [N-1:0]     gnt;
    logic             fifo_write_q;
    logic [WIDTH-1:0] data_q;
    logic [IW-1:0]    gnt_id_q;
    int unsigned      start;

    // The word still in flight counts as occupied; reads are ignored.
    assign occ  = {1'b0, bus.fifo_cnt} + {{CW{1'b0}}, fifo_write_q};
    assign room = (occ < (CW+1)'(DEPTH));

`ifdef FIFO_ARB_BURST_EN
    localparam int BW = ($clog2(MAX_BURST) > 2) ? $clog2(MAX_BURST) : 2;

    logic [BW-1:0] burst_cnt;
    logic          hold;

    assign hold  = bus.req[last_q] && (32'(burst_cnt) < 32'(MAX_BURST - 1));
    assign start = hold ? 32'(last_q) : (32'(last_q) + 1) % N;

    // burst_cnt holds (consecutive transfers to last) - 1; saturates when alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_cnt <= '0;
        end else if (found && (sel == last_q) && fifo_write_q) begin
            if (32'(burst_cnt) < 32'(MAX_BURST - 1))
                burst_cnt <= burst_cnt + 1'b1;
        end else begin
            burst_cnt <= '0;
        end
    end
`else
    logic unused_max_burst;

    assign unused_max_burst = ^MAX_BURST;
    assign start            = (32'(last_q) + 1) % N;
`endif

    always_comb begin
        gnt   = '0;
        sel   = '0;
        cand  = '0;
        found = 1'b0;
        if (!rst && room) begin
            for (int unsigned k = 0; k < N; k++) begin
                cand = IW'((start + k) % N);
                if (!found && bus.req[cand]) begin
                    found = 1'b1;
                    sel   = cand;
                end
            end
            if (found)
                gnt[sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_write_q <= 1'b0;
            data_q       <= '0;
            gnt_id_q     <= '0;
            last_q       <= IW'(N - 1);
        end else if (found) begin
            fifo_write_q <= 1'b1;
            data_q       <= bus.req_data[32'(sel)*WIDTH +: WIDTH];
            gnt_id_q     <= sel;
            last_q       <= sel;
        end else begin
            fifo_write_q <= 1'b0;
        end
    end

    assign bus.gnt          = gnt;
    assign bus.fifo_write   = fifo_write_q;
    assign bus.fifo_data_in = data_q;
    assign bus.gnt_id       = gnt_id_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and randomized self-checking bench for fifo_wr_arbiter (N=4, WIDTH=16, DEPTH=16).
module tb_fifo_wr_arbiter;
    localparam int N         = 4;
    localparam int WIDTH     = 16;
    localparam int DEPTH     = 16;
    localparam int MAX_BURST = 4;
`ifdef FIFO_ARB_BURST_EN
    localparam int STARVE = (N - 1) * MAX_BURST;
`else
    localparam int STARVE = N - 1;
`endif
    localparam logic [N*WIDTH-1:0] DATA0 = {16'hD333, 16'hC222, 16'hB111, 16'hA000};

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    fifo_wr_arbiter_if #(.N(N), .WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    fifo_wr_arbiter #(
        .N(N), .WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic apply_reset();
        @(negedge clk);
        rst          = 1'b1;
        bus.req      = '0;
        bus.fifo_cnt = '0;
        bus.req_data = DATA0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        bus.req = 4'b1111;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        tests++;
        if (bus.fifo_write !== 1'b1 || bus.gnt_id !== 2'd1) begin
            fails++;
            $display("FAIL reset_pre: fifo_write=%b gnt_id=%0d expected 1/1", bus.fifo_write, bus.gnt_id);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests++;
        if (bus.fifo_write !== 1'b0 || bus.gnt !== 4'b0000) begin
            fails++;
            $display("FAIL reset_async: fifo_write=%b gnt=%b expected 0/0000", bus.fifo_write, bus.gnt);
        end
        tests++;
        if (bus.gnt_id !== 2'd0 || bus.fifo_data_in !== 16'h0000) begin
            fails++;
            $display("FAIL reset_regs: gnt_id=%0d data=%h expected 0/0000", bus.gnt_id, bus.fifo_data_in);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (bus.gnt !== 4'b0001) begin
            fails++;
            $display("FAIL reset_first_gnt: gnt=%b expected 0001", bus.gnt);
        end
        @(posedge clk);
        #1;
        tests++;
        if (bus.fifo_write !== 1'b1 || bus.gnt_id !== 2'd0 || bus.fifo_data_in !== 16'hA000) begin
            fails++;
            $display("FAIL reset_first_write: fw=%b id=%0d data=%h expected 1/0/a000",
                     bus.fifo_write, bus.gnt_id, bus.fifo_data_in);
        end
    endtask

    task automatic test_round_robin();
        logic [N*WIDTH-1:0] dv;
        apply_reset();
        dv      = DATA0;
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            int i;
            i = k % N;
            #1;
            tests++;
            if (bus.gnt !== 4'(1 << i)) begin
                fails++;
                $display("FAIL rr_gnt[%0d]: gnt=%b expected %b", k, bus.gnt, 4'(1 << i));
            end
            @(posedge clk);
            #1;
            tests++;
            if (bus.fifo_write !== 1'b1 || bus.gnt_id !== 2'(i) || bus.fifo_data_in !== dv[i*WIDTH +: WIDTH]) begin
                fails++;
                $display("FAIL rr_write[%0d]: fw=%b id=%0d data=%h expected 1/%0d/%h",
                         k, bus.fifo_write, bus.gnt_id, bus.fifo_data_in, i, dv[i*WIDTH +: WIDTH]);
            end
            @(negedge clk);
        end
        bus.req = '0;
    endtask

    task automatic test_sparse_req();
        int ids [5] = '{1, 3, 1, 3, 1};
        apply_reset();
        bus.req = 4'b1010;
        for (int k = 0; k < 5; k++) begin
            #1;
            tests++;
            if (bus.gnt !== 4'(1 << ids[k])) begin
                fails++;
                $display("FAIL sparse_gnt[%0d]: gnt=%b expected %b", k, bus.gnt, 4'(1 << ids[k]));
            end
            @(posedge clk);
            #1;
            tests++;
            if (bus.gnt_id !== 2'(ids[k])) begin
                fails++;
                $display("FAIL sparse_id[%0d]: gnt_id=%0d expected %0d", k, bus.gnt_id, ids[k]);
            end
            @(negedge clk);
        end
        bus.req = '0;
    endtask

    task automatic test_throttle();
        logic [N-1:0] pats [4] = '{4'b1111, 4'b0001, 4'b1000, 4'b0110};
        logic [N-1:0] b2b  [3] = '{4'b1000, 4'b0001, 4'b0010};
        apply_reset();
        bus.req      = 4'b1111;
        bus.fifo_cnt = 5'd15;
        #1;
        tests++;
        if (bus.gnt !== 4'b0001) begin
            fails++;
            $display("FAIL thr_cnt15_idle: gnt=%b expected 0001", bus.gnt);
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        tests++;
        if (bus.gnt !== 4'b0000) begin
            fails++;
            $display("FAIL thr_cnt15_inflight: gnt=%b expected 0000", bus.gnt);
        end
        @(posedge clk);
        #1;
        tests++;
        if (bus.fifo_write !== 1'b0) begin
            fails++;
            $display("FAIL thr_no_write: fifo_write=%b expected 0", bus.fifo_write);
        end
        @(negedge clk);
        #1;
        tests++;
        if (bus.gnt !== 4'b0010) begin
            fails++;
            $display("FAIL thr_resume: gnt=%b expected 0010", bus.gnt);
        end
        @(posedge clk);
        @(negedge clk);
        bus.fifo_cnt = 5'd14;
        #1;
        tests++;
        if (bus.gnt !== 4'b0100) begin
            fails++;
            $display("FAIL thr_cnt14_inflight: gnt=%b expected 0100", bus.gnt);
        end
        @(posedge clk);
        @(negedge clk);
        bus.fifo_cnt = 5'd16;
        for (int k = 0; k < 4; k++) begin
            bus.req = pats[k];
            #1;
            tests++;
            if (bus.gnt !== 4'b0000) begin
                fails++;
                $display("FAIL thr_full_gnt[%0d]: gnt=%b expected 0000", k, bus.gnt);
            end
            @(posedge clk);
            #1;
            tests++;
            if (bus.fifo_write !== 1'b0) begin
                fails++;
                $display("FAIL thr_full_write[%0d]: fifo_write=%b expected 0", k, bus.fifo_write);
            end
            @(negedge clk);
        end
        bus.req      = 4'b1111;
        bus.fifo_cnt = 5'd0;
        for (int k = 0; k < 3; k++) begin
            #1;
            tests++;
            if (bus.gnt !== b2b[k]) begin
                fails++;
                $display("FAIL thr_b2b_gnt[%0d]: gnt=%b expected %b", k, bus.gnt, b2b[k]);
            end
            @(posedge clk);
            #1;
            tests++;
            if (bus.fifo_write !== 1'b1) begin
                fails++;
                $display("FAIL thr_b2b_write[%0d]: fifo_write=%b expected 1", k, bus.fifo_write);
            end
            @(negedge clk);
        end
        bus.req = '0;
    endtask

`ifdef FIFO_ARB_BURST_EN
    task automatic test_burst();
        logic [N-1:0] seq [12] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001,
                                   4'b0010, 4'b0010, 4'b0010, 4'b0010,
                                   4'b0001, 4'b0001, 4'b0001, 4'b0001};
        logic [N-1:0] drop [7] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010,
                                   4'b0010, 4'b0010, 4'b0001};
        apply_reset();
        bus.req = 4'b0011;
        for (int k = 0; k < 12; k++) begin
            #1;
            tests++;
            if (bus.gnt !== seq[k]) begin
                fails++;
                $display("FAIL burst_gnt[%0d]: gnt=%b expected %b", k, bus.gnt, seq[k]);
            end
            @(negedge clk);
        end
        apply_reset();
        bus.req = 4'b0011;
        for (int k = 0; k < 7; k++) begin
            bus.req = (k == 2) ? 4'b0010 : 4'b0011;
            #1;
            tests++;
            if (bus.gnt !== drop[k]) begin
                fails++;
                $display("FAIL burst_drop_gnt[%0d]: gnt=%b expected %b", k, bus.gnt, drop[k]);
            end
            @(negedge clk);
        end
        bus.req = '0;
    endtask
`endif

    task automatic test_random();
        logic [N-1:0]       r;
        logic [N-1:0]       g;
        logic [N*WIDTH-1:0] dv;
        logic               fw;
        int                 cnt;
        int                 gi;
        int                 waits [N];
        apply_reset();
        r  = '0;
        fw = 1'b0;
        for (int i = 0; i < N; i++) waits[i] = 0;
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++)
                if (!r[i] && $urandom_range(0, 1) == 1) r[i] = 1'b1;
            cnt          = $urandom_range(0, DEPTH);
            dv           = {$urandom, $urandom};
            bus.req      = r;
            bus.fifo_cnt = 5'(cnt);
            bus.req_data = dv;
            #1;
            g = bus.gnt;
            tests++;
            if (!$onehot0(g) || (g & ~r) != '0) begin
                fails++;
                $display("FAIL rand_onehot[%0d]: gnt=%b req=%b", c, g, r);
            end
            tests++;
            if ((g != '0) !== ((cnt + int'(fw)) < DEPTH && r != '0)) begin
                fails++;
                $display("FAIL rand_room[%0d]: gnt=%b req=%b cnt=%0d inflight=%b", c, g, r, cnt, fw);
            end
            gi = 0;
            for (int i = 0; i < N; i++) if (g[i]) gi = i;
            @(posedge clk);
            #1;
            tests++;
            if (bus.fifo_write !== (g != '0)) begin
                fails++;
                $display("FAIL rand_write[%0d]: fifo_write=%b expected %b", c, bus.fifo_write, g != '0);
            end
            if (g != '0) begin
                tests++;
                if (bus.gnt_id !== 2'(gi) || bus.fifo_data_in !== dv[gi*WIDTH +: WIDTH]) begin
                    fails++;
                    $display("FAIL rand_data[%0d]: id=%0d data=%h expected %0d/%h",
                             c, bus.gnt_id, bus.fifo_data_in, gi, dv[gi*WIDTH +: WIDTH]);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (g[i]) begin
                    waits[i] = 0;
                    if ($urandom_range(0, 1) == 1) r[i] = 1'b0;
                end else if (r[i] && g != '0) begin
                    waits[i]++;
                    tests++;
                    if (waits[i] > STARVE) begin
                        fails++;
                        $display("FAIL rand_starve[%0d]: req %0d waited %0d grants, limit %0d",
                                 c, i, waits[i], STARVE);
                    end
                end
            end
            fw = (g != '0);
            @(negedge clk);
        end
        bus.req = '0;
    endtask

    initial begin
        rst          = 1'b1;
        bus.req      = '0;
        bus.req_data = DATA0;
        bus.fifo_cnt = '0;
        test_reset();
        test_round_robin();
        test_sparse_req();
        test_throttle();
`ifdef FIFO_ARB_BURST_EN
        test_burst();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
